sdram_dev_model: RTL and testbench

Synthesizable single-rank SDR SDRAM device responder for the pin-level bus driven by the team's SDRAM controller. It sits on the far side of that bus in simulation and FPGA-emulation builds and replaces the external SDRAM chip. It decodes CS/RAS/CAS/WE commands, tracks open rows per bank and programs burst length and CAS latency from MRS. It services read and write bursts against an internal word array, with DQM byte masking, and flags protocol violations.

---
 rtl/sdram_dev_model.sv | 117 +++++++++++
 tb/tb_sdram_dev_model.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_dev_model.sv
// sdram_dev_model: pin-level SDR SDRAM device responder backed by an internal word array.
//   clk_i    device clock (controller's sdram_clk); commands sampled on the rising edge
//   rst_i    asynchronous active-low reset
//   cke_i    clock enable; low freezes command decode, burst counter, delay line and outputs
//   cs_i/ras_i/cas_i/we_i  active-low command strobes
//   ba_i     bank address; addr_i row/column/mode address, A10 = auto-precharge / all banks
//   dqm_i    write byte masks (1 = keep old lane); dq_i write data
//   dq_o     read data, valid while dq_oe_o is high
//   err_o    sticky protocol-violation flag
module sdram_dev_model #(
   parameter int MEM_AW = 12,
   parameter int ROW_W  = 13,
   parameter int COL_W  = 10
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cke_i,
   input  logic        cs_i,
   input  logic        ras_i,
   input  logic        cas_i,
   input  logic        we_i,
   input  logic [1:0]  ba_i,
   input  logic [12:0] addr_i,
   input  logic [3:0]  dqm_i,
   input  logic [31:0] dq_i,
   output logic [31:0] dq_o,
   output logic        dq_oe_o,
   output logic        err_o
);
   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
   localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100, C_BST = 3'b110;
   localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;
   logic [31:0]      mem [2**MEM_AW];
   state_t           state_q, state_d;
   logic [3:0]       open_q, open_d;
   logic [ROW_W-1:0] row_q [4];
   logic [1:0]       bl_lg_q;
   logic             cl3_q;
   logic [1:0]       bba_q;
   logic [COL_W-1:0] bcol_q;
   logic [2:0]       bk_q;
   logic             bap_q;
   logic [32:0]      p1_q, p2_q;
   logic [2:0]       cmd, bl_m, iss_k;
   logic             rw_cmd, rw_ok, bst, bad, iss, iss_wr, iss_ap, iss_last;
   logic [1:0]       iss_ba;
   logic [COL_W-1:0] iss_c0, iss_col;
   logic [MEM_AW-1:0] iss_a;
   logic [31:0]      rdata, wdata;
   always_comb begin
      // deselect or cke low decodes as NOP
      cmd      = (cke_i && !cs_i) ? {ras_i, cas_i, we_i} : 3'b111;
      rw_cmd   = cmd == C_RD || cmd == C_WR;
      rw_ok    = rw_cmd && open_q[ba_i];
      bst      = cmd == C_BST;
      bad      = (cmd == C_ACT && open_q[ba_i]) || (rw_cmd && !open_q[ba_i]) || (cmd == C_REF && |open_q);
      bl_m     = 3'((4'd1 << bl_lg_q) - 4'd1);
      // a new READ/WRITE issues its beat 0 in the command cycle and preempts any running burst
      iss      = rw_ok || (cke_i && state_q != S_IDLE);
      iss_wr   = rw_ok ? cmd == C_WR : state_q == S_WR;
      iss_ba   = rw_ok ? ba_i : bba_q;
      iss_c0   = rw_ok ? addr_i[COL_W-1:0] : bcol_q;
      iss_k    = rw_ok ? 3'd0 : bk_q;
      iss_ap   = rw_ok ? addr_i[10] : bap_q;
      iss_last = iss_k == bl_m;
      // low log2(BL) column bits wrap inside the BL-aligned block
      iss_col  = {iss_c0[COL_W-1:3], (iss_c0[2:0] & ~bl_m) | ((iss_c0[2:0] + iss_k) & bl_m)};
      iss_a    = MEM_AW'({iss_ba, row_q[iss_ba], iss_col});
      rdata    = mem[iss_a];
      wdata    = dq_i;
      for (int i = 0; i < 4; i++) wdata[8*i +: 8] = dqm_i[i] ? rdata[8*i +: 8] : dq_i[8*i +: 8];
      state_d  = !cke_i ? state_q :
                 rw_ok ? (bl_lg_q == 2'd0 ? S_IDLE : cmd == C_WR ? S_WR : S_RD) :
                 (bst || iss_last) ? S_IDLE : state_q;
      open_d   = open_q;
      if (iss && iss_last && iss_ap) open_d[iss_ba] = 1'b0;
      if (cmd == C_ACT) open_d[ba_i] = 1'b1;
      if (cmd == C_PRE) open_d = addr_i[10] ? 4'b0 : open_d & ~(4'b1 << ba_i);
   end
   always_ff @(posedge clk_i) if (iss && iss_wr) mem[iss_a] <= wdata;
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         state_q <= S_IDLE;
         open_q  <= '0;
         row_q   <= '{default: '0};
         bl_lg_q <= 2'd0;
         cl3_q   <= 1'b0;
         bba_q   <= 2'd0;
         bcol_q  <= '0;
         bk_q    <= 3'd0;
         bap_q   <= 1'b0;
         p1_q    <= '0;
         p2_q    <= '0;
         dq_o    <= '0;
         dq_oe_o <= 1'b0;
         err_o   <= 1'b0;
      end else if (cke_i) begin
         state_q <= state_d;
         open_q  <= open_d;
         err_o   <= err_o | bad;
         if (rw_ok) begin
            bba_q  <= ba_i;
            bcol_q <= addr_i[COL_W-1:0];
            bap_q  <= addr_i[10];
            bk_q   <= 3'd1;
         end else if (state_q != S_IDLE) bk_q <= bk_q + 3'd1;
         if (cmd == C_ACT) row_q[ba_i] <= addr_i[ROW_W-1:0];
         if (cmd == C_MRS) begin
            bl_lg_q <= addr_i[2] ? 2'd0 : addr_i[1:0];
            cl3_q   <= addr_i[6:4] == 3'b011;
         end
         // CL-deep delay line: stage 1 always, stage 2 only for CL3
         p1_q <= (iss && !iss_wr) ? {1'b1, rdata} : '0;
         p2_q <= p1_q;
         {dq_oe_o, dq_o} <= cl3_q ? p2_q : p1_q;
      end
endmodule

// File: tb/tb_sdram_dev_model.sv
// tb_sdram_dev_model: randomized and directed bench with a scoreboard-based read-beat checker.
module tb_sdram_dev_model;
   localparam int AW = 12;
   localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100;
   localparam logic [2:0] BST = 3'b110, PRE = 3'b010, REF = 3'b001, MRS = 3'b000;
   typedef struct {int t; bit wr; int wa; bit ap; int apb;} iss_t;
   typedef struct {int t; bit known; logic [31:0] d;} exp_t;
   logic clk = 0, rst_n = 1, cke = 1, cs = 1, ras = 1, cas = 1, we = 1;
   logic [1:0] ba = 0;
   logic [12:0] addr = 0;
   logic [3:0] dqm = 0;
   logic [31:0] dq_in = 0, dq_out;
   logic dq_oe, err;
   iss_t pend[$];
   exp_t sb[$];
   exp_t e;
   logic [31:0] mem_m [1<<AW];
   bit vld [1<<AW];
   bit open_m [4];
   int row_m [4];
   int bl_m = 1, cl_m = 2, mt = 0, nvec = 0, nerr = 0;
   bit err_m = 0, err_vis = 0, en_vis = 0, in_rst = 1;

   sdram_dev_model dut (.clk_i(clk), .rst_i(rst_n), .cke_i(cke), .cs_i(cs), .ras_i(ras), .cas_i(cas),
      .we_i(we), .ba_i(ba), .addr_i(addr), .dqm_i(dqm), .dq_i(dq_in), .dq_o(dq_out), .dq_oe_o(dq_oe),
      .err_o(err));

   always #5 clk = ~clk;

   function automatic int word(int b, int r, int c);
      return (b * (1 << 23) + r * 1024 + c) % (1 << AW);
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL %s got %h required %h", nm, got, exp); end
   endtask

   // One device cycle: drive pins, advance the reference model, cross the clock edge.
   task automatic step(input bit ke, input bit s, input logic [2:0] c, input logic [1:0] b,
                       input logic [12:0] a, input logic [3:0] m, input logic [31:0] d);
      logic [2:0] k;
      iss_t p;
      exp_t x;
      int c0;
      cke = ke; cs = s; {ras, cas, we} = c; ba = b; addr = a; dqm = m; dq_in = d;
      k = s ? NOP : c;
      if (ke) begin
         if ((k == RD || k == WR) && !open_m[b]) begin err_m = 1; k = NOP; end
         if (k == RD || k == WR) begin
            pend.delete();
            c0 = int'(a[9:0]);
            for (int i = 0; i < bl_m; i++) begin
               p.t = mt + i; p.wr = (k == WR);
               p.wa = word(int'(b), row_m[b], c0 - c0 % bl_m + (c0 + i) % bl_m);
               p.ap = a[10] && (i == bl_m - 1); p.apb = int'(b);
               pend.push_back(p);
            end
         end
         if (k == BST) while (pend.size() > 0 && pend[$].t > mt) void'(pend.pop_back());
         if (pend.size() > 0 && pend[0].t == mt) begin
            p = pend.pop_front();
            if (p.wr) begin
               for (int i = 0; i < 4; i++) if (!m[i]) mem_m[p.wa][8*i +: 8] = d[8*i +: 8];
               vld[p.wa] = vld[p.wa] || (m == 4'h0);
            end else begin
               x.t = mt + cl_m; x.known = vld[p.wa]; x.d = mem_m[p.wa];
               sb.push_back(x);
            end
            if (p.ap) open_m[p.apb] = 0;
         end
         case (k)
            ACT: begin if (open_m[b]) err_m = 1; open_m[b] = 1; row_m[b] = int'(a); end
            PRE: if (a[10]) open_m = '{default: 0}; else open_m[b] = 0;
            REF: if (open_m[0] || open_m[1] || open_m[2] || open_m[3]) err_m = 1;
            MRS: begin
               case (a[2:0]) 3'd1: bl_m = 2; 3'd2: bl_m = 4; 3'd3: bl_m = 8; default: bl_m = 1; endcase
               cl_m = (a[6:4] == 3'b011) ? 3 : 2;
            end
            default: ;
         endcase
      end
      @(posedge clk);
      if (ke) mt++;
      en_vis = ke; err_vis = err_m;
      #1;
   endtask

   task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
      step(1'b1, 1'b0, c, b, a, 4'($urandom), $urandom);
   endtask

   // deselected cycles carry random strobes that must be ignored
   task automatic nop(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 3'($urandom), 2'($urandom), 13'($urandom), 4'($urandom), $urandom);
   endtask

   task automatic do_reset();
      cke = 1; cs = 1; rst_n = 0; in_rst = 1;
      #1;
      chk("reset dq_oe_o", 32'(dq_oe), 32'h0);
      chk("reset err_o", 32'(err), 32'h0);
      chk("reset dq_o", dq_out, 32'h0);
      pend.delete(); sb.delete();
      open_m = '{default: 0};
      foreach (vld[i]) vld[i] = 0;
      bl_m = 1; cl_m = 2; err_m = 0; err_vis = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1;
      @(posedge clk);
      #1;
      in_rst = 0; en_vis = 1; mt++;
   endtask

   always @(negedge clk) if (!in_rst) begin
      nvec++;
      if (err !== err_vis) begin nerr++; $display("FAIL err_o t=%0d got %b required %b", mt, err, err_vis); end
      if (en_vis) begin
         if (dq_oe === 1'b1) begin
            nvec++;
            if (sb.size() == 0) begin
               nerr++; $display("FAIL beat t=%0d got unexpected dq_oe_o=1 data %h, required idle", mt, dq_out);
            end else begin
               e = sb.pop_front();
               if (e.t != mt || (e.known && dq_out !== e.d)) begin
                  nerr++; $display("FAIL beat t=%0d got %h, required %h at t=%0d", mt, dq_out, e.d, e.t);
               end
            end
         end else if (sb.size() > 0 && sb[0].t <= mt) begin
            nvec++; nerr++; e = sb.pop_front();
            $display("FAIL beat t=%0d got dq_oe_o=%b, required beat %h", mt, dq_oe, e.d);
         end
      end
   end

   initial begin
      logic [12:0] a;
      int r;
      #1 do_reset();
      // basic burst: BL4 CL2, zero-fill then masked write, then read back
      cmd(MRS, 2'd0, 13'h022);
      cmd(ACT, 2'd1, 13'd5);
      for (int k = 0; k < 4; k++) step(1'b1, k != 0, k == 0 ? WR : NOP, 2'd1, 13'd8, 4'h0, 32'h0);
      for (int k = 0; k < 4; k++)
         step(1'b1, k != 0, k == 0 ? WR : NOP, 2'd1, 13'd8, k == 2 ? 4'b0011 : 4'b0000, {4{8'hA0 + 8'(k)}});
      nop(1);
      cmd(RD, 2'd1, 13'd8);
      nop(6);
      // wrap order
      cmd(RD, 2'd1, 13'h00A);
      nop(6);
      // CL3 BL8 with burst stop two cycles after the read
      cmd(MRS, 2'd0, 13'h033);
      cmd(RD, 2'd1, 13'd8);
      nop(1);
      cmd(BST, 2'd0, 13'd0);
      nop(10);
      // clock-enable freeze mid-read
      cmd(MRS, 2'd0, 13'h022);
      cmd(RD, 2'd1, 13'd8);
      nop(2);
      step(1'b0, 1'b1, NOP, 2'd0, 13'd0, 4'h0, 32'h0);
      step(1'b0, 1'b0, RD, 2'd1, 13'd8, 4'h0, 32'h0);
      nop(8);
      // auto-precharge closes the bank; the next read to it is a violation
      cmd(ACT, 2'd3, 13'd0);
      cmd(RD, 2'd3, 13'h400);
      nop(6);
      cmd(RD, 2'd3, 13'd0);
      nop(4);
      // reset during beat 1 of a read
      cmd(ACT, 2'd0, 13'd0);
      cmd(RD, 2'd0, 13'd8);
      nop(2);
      #2 do_reset();
      // defaults after reset: BL1 CL2, banks closed
      cmd(REF, 2'd0, 13'd0);
      cmd(ACT, 2'd2, 13'd5);
      step(1'b1, 1'b0, WR, 2'd2, 13'd3, 4'h0, 32'h1234_5678);
      cmd(RD, 2'd2, 13'd3);
      nop(4);
      cmd(ACT, 2'd2, 13'd5);
      nop(2);
      // random traffic on four open banks over a pre-filled region
      cmd(PRE, 2'd0, 13'h400);
      for (int b = 0; b < 4; b++) cmd(ACT, 2'(b), 13'd0);
      cmd(MRS, 2'd0, 13'h023);
      for (int j = 0; j < 8; j++)
         for (int i = 0; i < 8; i++) step(1'b1, i != 0, i == 0 ? WR : NOP, 2'($urandom), 13'(j * 8), 4'h0, $urandom);
      nop(4);
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 15);
         a = 13'($urandom_range(0, 63));
         if (r == 0) begin
            nop(12);
            a = 13'($urandom_range(0, 15));
            a[6:4] = $urandom_range(0, 1) ? 3'd3 : 3'($urandom_range(0, 7));
            cmd(MRS, 2'd0, a);
         end else if (r == 1) cmd(BST, 2'd0, 13'd0);
         else if (r == 2) step(1'b0, 1'b0, 3'($urandom), 2'($urandom), 13'($urandom), 4'($urandom), $urandom);
         else if (r <= 8) cmd(RD, 2'($urandom), a);
         else if (r <= 14) cmd(WR, 2'($urandom), a);
         else nop(1);
      end
      nop(14);
      nvec++;
      if (sb.size() != 0) begin nerr++; $display("FAIL drain got %0d undelivered beats, required 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
